// File: rtl/cordic_req_sched.sv
// Two-requester scheduler for a shared CORDIC/output-select path.
// Round-robin grant, one launch per operation, WAIT timeout, registered response.
`timescale 1ns/1ps
module cordic_req_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_angle,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_angle,
    output logic        req1_ready,
    output logic        core_start,
    output logic [3:0]  core_select,
    output logic [31:0] core_angle,
    input  logic        core_valid,
    input  logic [16:0] core_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [16:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic        ready0_q, ready0_d;
    logic        ready1_q, ready1_d;
    logic        start_q, start_d;
    logic [3:0]  select_q, select_d;
    logic [31:0] angle_q, angle_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [16:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;

    logic        grant1;
    logic [1:0]  grant_op;

    // On a tie the requester that did not win last time is granted.
    assign grant1   = req1_valid && (!req0_valid || !last_q);
    assign grant_op = grant1 ? req1_op : req0_op;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        id_d        = id_q;
        ready0_d    = 1'b0;
        ready1_d    = 1'b0;
        start_d     = 1'b0;
        select_d    = select_q;
        angle_d     = angle_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    ready0_d = !grant1;
                    ready1_d = grant1;
                    last_d   = grant1;
                    id_d     = grant1;
                    start_d  = 1'b1;
                    angle_d  = grant1 ? req1_angle : req0_angle;
                    unique case (grant_op)
                        2'b01:   select_d = 4'b0001;
                        2'b10:   select_d = 4'b0010;
                        2'b11:   select_d = 4'b0100;
                        default: select_d = 4'b0000;
                    endcase
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // core_valid is tested first so it wins over a coincident timeout.
                if (core_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = core_result;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            start_q     <= 1'b0;
            select_q    <= '0;
            angle_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            ready0_q    <= ready0_d;
            ready1_q    <= ready1_d;
            start_q     <= start_d;
            select_q    <= select_d;
            angle_q     <= angle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req0_ready  = ready0_q;
    assign req1_ready  = ready1_q;
    assign core_start  = start_q;
    assign core_select = select_q;
    assign core_angle  = angle_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cordic_req_sched.sv
// Bench for cordic_req_sched: directed and random operations checked against a
// transaction-level model of grant order, response timing and timeout outcome.
`timescale 1ns/1ps
module tb_cordic_req_sched;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_angle, req1_angle;
    logic        req0_ready, req1_ready;
    logic        core_start;
    logic [3:0]  core_select;
    logic [31:0] core_angle;
    logic        core_valid;
    logic [16:0] core_result;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic [16:0] rsp_data;

    int total = 0;
    int bad   = 0;
    int exp_last = 1;

    always #5 clk = ~clk;

    cordic_req_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_angle(req0_angle), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_angle(req1_angle), .req1_ready(req1_ready),
        .core_start(core_start), .core_select(core_select), .core_angle(core_angle),
        .core_valid(core_valid), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sel_of(input logic [1:0] op);
        case (op)
            2'b01:   return 4'b0001;
            2'b10:   return 4'b0010;
            2'b11:   return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_op     = 2'($urandom);
        req1_op     = 2'($urandom);
        req0_angle  = $urandom;
        req1_angle  = $urandom;
        core_valid  = 1'b0;
        core_result = 17'($urandom);
    endtask

    // One full operation. Called at a negedge with the scheduler in IDLE.
    // d = cycles after the core_start cycle at which core_valid pulses (0 = never).
    task automatic do_op(input bit v0, input bit v1, input logic [1:0] op0, input logic [1:0] op1,
                         input logic [31:0] a0, input logic [31:0] a1, input int d,
                         input logic [16:0] res, input bit hold);
        int         g;
        int         exp_rsp;
        bit         exp_err;
        bit         done;
        logic [1:0] op;
        logic [31:0] ang;

        req0_valid = v0; req0_op = op0; req0_angle = a0;
        req1_valid = v1; req1_op = op1; req1_angle = a1;
        core_valid = 1'b0;

        if (v0 && v1) g = (exp_last == 0) ? 1 : 0;
        else          g = v1 ? 1 : 0;
        exp_last = g;
        op  = (g == 1) ? op1 : op0;
        ang = (g == 1) ? a1 : a0;

        exp_err = (d == 0) || (d > TO);
        exp_rsp = (exp_err ? TO : d) + 1;

        @(negedge clk);
        chk("accept_ready0", 32'(req0_ready), 32'(g == 0));
        chk("accept_ready1", 32'(req1_ready), 32'(g == 1));
        chk("issue_start", 32'(core_start), 32'd1);
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_select", 32'(core_select), 32'(sel_of(op)));
        chk("issue_angle", core_angle, ang);
        chk("issue_no_rsp", 32'(rsp_valid), 32'd0);

        if (!hold) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_op = 2'($urandom); req1_op = 2'($urandom);
            req0_angle = $urandom; req1_angle = $urandom;
        end

        done = 1'b0;
        for (int cyc = 1; cyc <= TO + 8; cyc++) begin
            @(negedge clk);
            chk("rsp_valid", 32'(rsp_valid), 32'(cyc == exp_rsp));
            chk("ready0_quiet", 32'(req0_ready), 32'd0);
            chk("ready1_quiet", 32'(req1_ready), 32'd0);
            chk("start_once", 32'(core_start), 32'd0);
            chk("busy", 32'(busy), 32'(cyc <= exp_rsp));
            chk("select_hold", 32'(core_select), 32'(sel_of(op)));
            chk("angle_hold", core_angle, ang);
            if (cyc == exp_rsp) begin
                chk("rsp_id", 32'(rsp_id), 32'(g));
                chk("rsp_data", 32'(rsp_data), exp_err ? 32'd0 : 32'(res));
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            core_valid  = (cyc == d);
            core_result = (cyc == d) ? res : 17'($urandom);
            if (cyc >= exp_rsp + 1 && (hold || d == 0 || cyc >= d + 1)) begin
                done = 1'b1;
                break;
            end
        end
        core_valid = 1'b0;
        chk("op_done", 32'(done), 32'd1);
    endtask

    // Launch a req1 operation and pull reset at the given cycle after core_start.
    task automatic reset_mid(input int at);
        req1_valid = 1'b1; req1_op = 2'b11; req1_angle = $urandom;
        @(negedge clk);
        chk("rst_pre_ready1", 32'(req1_ready), 32'd1);
        chk("rst_pre_start", 32'(core_start), 32'd1);
        req1_valid = 1'b0;
        repeat (at) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_select", 32'(core_select), 32'd0);
        chk("rst_angle", core_angle, 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1;
        repeat (TO + 3) begin
            core_valid  = 1'($urandom);
            core_result = 17'($urandom);
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        core_valid = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        bit         hold;
        int         d;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready0", 32'(req0_ready), 32'd0);
        chk("reset_ready1", 32'(req1_ready), 32'd0);
        chk("reset_start", 32'(core_start), 32'd0);
        chk("reset_select", 32'(core_select), 32'd0);
        chk("reset_angle", core_angle, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // sin on req0, result three cycles after launch
        do_op(1, 0, 2'b01, 2'b00, 32'h0000_8000, 32'h0, 3, 17'h07AC0, 0);
        // tan on req1 with the core silent: timeout response
        do_op(0, 1, 2'b00, 2'b11, 32'h0, 32'h1234_5678, 0, 17'h0, 0);
        // core_valid lands on the final WAIT cycle
        do_op(1, 0, 2'b10, 2'b00, 32'hFFFF_0000, 32'h0, TO, 17'h1ABCD, 0);
        // core_valid one cycle too late: timeout, then a spurious pulse in IDLE
        do_op(0, 1, 2'b00, 2'b00, 32'h0, 32'h0001_0000, TO + 1, 17'h00F0F, 0);

        repeat (3) begin
            core_valid  = 1'b1;
            core_result = 17'($urandom);
            @(negedge clk);
            chk("spurious_no_rsp", 32'(rsp_valid), 32'd0);
            chk("spurious_idle", 32'(busy), 32'd0);
        end
        core_valid = 1'b0;

        reset_mid(2);

        // both held valid from a fresh reset: grants 0,1,0
        for (int i = 0; i < 3; i++)
            do_op(1, 1, 2'b01, 2'b10, $urandom, $urandom, 1, 17'($urandom), 1);
        idle_inputs();
        @(negedge clk);

        reset_mid(0);

        for (int i = 0; i < 24; i++) begin
            r    = 2'($urandom_range(1, 3));
            hold = 1'($urandom);
            d    = hold ? int'($urandom_range(1, TO)) : int'($urandom_range(0, TO + 3));
            do_op(r[0], r[1], 2'($urandom), 2'($urandom), $urandom, $urandom, d,
                  17'($urandom), hold);
            if (hold) begin
                idle_inputs();
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_req_sched.md
CORDIC_REQ_SCHED -- requirements
Module: cordic_req_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: number of WAIT cycles before abandoning a core operation (valid range 2..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports req0_op / req1_op  input  2  operation code: 00 angle, 01 sin, 10 cos, 11 tan.
REQ-006 SHALL have ports req0_angle / req1_angle  input  32  Q16.16 operand for requester N.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  one-cycle acceptance pulse to requester N.
REQ-008 SHALL have port core_start  output  1  one-cycle launch strobe to the shared CORDIC/output-select path.
REQ-009 SHALL have port core_select  output  4  one-hot function select: sin 0001, cos 0010, tan 0100, angle 0000.
REQ-010 SHALL have port core_angle  output  32  registered operand for the launched operation.
REQ-011 SHALL have port core_valid  input  1  result-valid pulse from the shared path.
REQ-012 SHALL have port core_result  input  17  result word from the shared path.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have port rsp_id  output  1  requester index that owns the response.
REQ-015 SHALL have port rsp_data  output  17  captured core_result; zero on timeout.
REQ-016 SHALL have port rsp_err  output  1  1 when the response is a timeout.
REQ-017 SHALL have port busy  output  1  1 in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; every output registered.
REQ-019 IDLE: if any reqN_valid, SHALL grant one requester, pulse its reqN_ready, latch op/angle/id, go to ISSUE next cycle; otherwise stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; single valid requester is always granted; last-grant pointer resets to 1 (so req0 wins first tie).
REQ-021 ISSUE: SHALL drive core_start=1 for exactly one cycle with core_select/core_angle from the latched op/angle, clear the timeout counter, go to WAIT.
REQ-022 core_select and core_angle SHALL hold stable from ISSUE until the next ISSUE (required by the multi-cycle tan divider).
REQ-023 WAIT: on core_valid=1, SHALL capture core_result, go to RESP with rsp_err=0.
REQ-024 WAIT: counter SHALL increment each cycle without core_valid; when it reaches TIMEOUT-1 without core_valid, SHALL go to RESP with rsp_data=0, rsp_err=1.
REQ-025 If core_valid and timeout occur in the same cycle, core_valid SHALL win (rsp_err=0).
REQ-026 core_valid outside WAIT SHALL be ignored (no capture, no state change).
REQ-027 RESP: SHALL pulse rsp_valid for one cycle with rsp_id/rsp_data/rsp_err held, then return to IDLE; requests are not accepted in RESP.
REQ-028 Minimum request-to-response latency SHALL be 4 cycles (IDLE accept, ISSUE, WAIT with core_valid, RESP); back-to-back throughput one op per 4 cycles minimum.
REQ-029 reqN_ready SHALL be asserted only in IDLE and never for both requesters in one cycle.
REQ-030 A requester deasserting reqN_valid after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, counter 0, last-grant pointer 1, and all outputs 0 (core_select 0000, core_angle 0, rsp_data 0).
REQ-032 Reset asserted mid-operation SHALL abandon it with no rsp_valid; after rst_n rises, the first edge samples requests in IDLE.

Verification
REQ-033 req0 op=01 angle=0x00008000, core_valid 3 cycles after core_start with result 0x07AC0 -> core_select=0001, rsp_valid with rsp_id=0, rsp_data=0x07AC0, rsp_err=0.
REQ-034 req0 and req1 both held valid for 3 ops -> grants alternate 0,1,0; each ready a single pulse.
REQ-035 TIMEOUT=8, op=11, core_valid never asserted -> rsp_valid 8 WAIT cycles after ISSUE, rsp_err=1, rsp_data=0, FSM back to IDLE.
REQ-036 core_valid on the exact timeout cycle -> rsp_err=0 with captured data; spurious core_valid in IDLE -> no rsp_valid.
REQ-037 rst_n pulsed low during WAIT -> busy, core_start, rsp_valid all 0 immediately; no response emitted; next request served normally.
